// File: rtl/instr_type.sv
// Shared decode types: arithmetic kinds, major opcodes and funct7 encodings
// for the OP / OP-IMM decode stage.
package instr_type;

  typedef enum logic [4:0] {
    ak_invalid,
    ak_addi, ak_slti, ak_sltiu, ak_xori, ak_ori, ak_andi,
    ak_slli, ak_srli, ak_srai,
    ak_add, ak_sub, ak_sll, ak_slt, ak_sltu, ak_xor, ak_srl, ak_sra, ak_or, ak_and,
    ak_mul, ak_mulh, ak_mulhsu, ak_mulhu, ak_div, ak_divu, ak_rem, ak_remu
  } arith_kind_t;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Immediate shifts carry a shamt in the immediate field instead of a signed value.
  function automatic logic is_imm_shift(input arith_kind_t kind);
    return (kind == ak_slli) || (kind == ak_srli) || (kind == ak_srai);
  endfunction

endpackage

// File: rtl/arith_kind_lut.sv
// Combinational opcode/funct3/funct7 -> arith kind lookup.
// M-extension encodings decode only when DECODE_ARITH_M_EXT_EN is defined.
module arith_kind_lut
  import instr_type::*;
#(
  parameter int XLEN = 32
) (
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output arith_kind_t kind,
  output logic        illegal
);

  // RV64 borrows funct7[0] as shamt[5], so only the upper six bits qualify the shift.
  logic sh_base;
  logic sh_alt;
  assign sh_base = (XLEN == 64) ? (funct7[6:1] == F7_BASE[6:1]) : (funct7 == F7_BASE);
  assign sh_alt  = (XLEN == 64) ? (funct7[6:1] == F7_ALT[6:1])  : (funct7 == F7_ALT);

  always_comb begin
    kind = ak_invalid;
    case (opcode)
      OPC_OP_IMM: begin
        case (funct3)
          3'b000:  kind = ak_addi;
          3'b010:  kind = ak_slti;
          3'b011:  kind = ak_sltiu;
          3'b100:  kind = ak_xori;
          3'b110:  kind = ak_ori;
          3'b111:  kind = ak_andi;
          3'b001:  kind = sh_base ? ak_slli : ak_invalid;
          3'b101:  kind = sh_base ? ak_srli : (sh_alt ? ak_srai : ak_invalid);
          default: kind = ak_invalid;
        endcase
      end
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  kind = ak_add;
            3'b001:  kind = ak_sll;
            3'b010:  kind = ak_slt;
            3'b011:  kind = ak_sltu;
            3'b100:  kind = ak_xor;
            3'b101:  kind = ak_srl;
            3'b110:  kind = ak_or;
            3'b111:  kind = ak_and;
            default: kind = ak_invalid;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000)      kind = ak_sub;
          else if (funct3 == 3'b101) kind = ak_sra;
        end
`ifdef DECODE_ARITH_M_EXT_EN
        else if (funct7 == F7_MULDIV) begin
          case (funct3)
            3'b000:  kind = ak_mul;
            3'b001:  kind = ak_mulh;
            3'b010:  kind = ak_mulhsu;
            3'b011:  kind = ak_mulhu;
            3'b100:  kind = ak_div;
            3'b101:  kind = ak_divu;
            3'b110:  kind = ak_rem;
            3'b111:  kind = ak_remu;
            default: kind = ak_invalid;
          endcase
        end
`endif
      end
      default: kind = ak_invalid;
    endcase
  end

  assign illegal = (kind == ak_invalid);

endmodule

// File: rtl/decode_arith_stage.sv
// Registered OP / OP-IMM decode stage with a two-entry skid buffer.
// Optional feature macro: DECODE_ARITH_M_EXT_EN (M-extension decode in arith_kind_lut).
module decode_arith_stage
  import instr_type::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output arith_kind_t     out_kind,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic            out_use_imm,
  output logic            out_illegal
);

  localparam int SHW = (XLEN == 64) ? 6 : 5;

  typedef struct packed {
    arith_kind_t     kind;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            illegal;
  } entry_t;

  entry_t      main_q, skid_q, dec;
  logic        main_v, skid_v, ready_q;
  arith_kind_t dec_kind;
  logic        dec_illegal;

  arith_kind_lut #(.XLEN(XLEN)) u_lut (
    .opcode  (in_instr[6:0]),
    .funct3  (in_instr[14:12]),
    .funct7  (in_instr[31:25]),
    .kind    (dec_kind),
    .illegal (dec_illegal)
  );

  always_comb begin
    dec         = '0;
    dec.kind    = dec_kind;
    dec.rd      = in_instr[11:7];
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.use_imm = (in_instr[6:0] == OPC_OP_IMM);
    dec.illegal = dec_illegal;
    dec.imm     = is_imm_shift(dec_kind) ? {{(XLEN-SHW){1'b0}}, in_instr[20 +: SHW]}
                                         : {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  end

  // Handshake: a word moves on a side only in a cycle where valid && ready are both 1;
  // once out_valid rises it stays high with a stable payload until out_ready is seen.
  logic accept, main_free;
  assign accept    = in_valid && ready_q;
  assign main_free = !main_v || out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_v  <= 1'b0;
      skid_v  <= 1'b0;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      main_v  <= 1'b0;
      skid_v  <= 1'b0;
      ready_q <= 1'b1;
    end else if (main_free) begin
      // ready_q is low whenever skid holds data, so the refill never races an accept.
      if (skid_v) begin
        main_q  <= skid_q;
        main_v  <= 1'b1;
        skid_v  <= 1'b0;
        ready_q <= 1'b1;
      end else begin
        main_v <= accept;
        if (accept) main_q <= dec;
      end
    end else if (accept) begin
      skid_q  <= dec;
      skid_v  <= 1'b1;
      ready_q <= 1'b0;
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = main_v;
  assign out_kind    = main_q.kind;
  assign out_rd      = main_q.rd;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_imm     = main_q.imm;
  assign out_use_imm = main_q.use_imm;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_arith_stage.sv
// Bench for decode_arith_stage: directed decode table on XLEN=32 (plus an XLEN=64
// instance for shamt rules) and hand-written handshake / flush / reset sequences.
module tb_decode_arith_stage;
  import instr_type::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] in_instr = '0;

  logic        in_ready, out_valid, out_use_imm, out_illegal;
  arith_kind_t out_kind;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm;

  logic        w_in_ready, w_out_valid, w_use_imm, w_illegal;
  arith_kind_t w_kind;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [63:0] w_imm;

  int n_tests = 0;
  int n_fail  = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  decode_arith_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_use_imm(out_use_imm), .out_illegal(out_illegal)
  );

  decode_arith_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_instr(in_instr), .out_valid(w_out_valid), .out_ready(out_ready), .out_kind(w_kind),
    .out_rd(w_rd), .out_rs1(w_rs1), .out_rs2(w_rs2), .out_imm(w_imm),
    .out_use_imm(w_use_imm), .out_illegal(w_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    arith_kind_t kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        chk_imm;
    logic        use_imm;
    logic        illegal;
  } vec_t;

  vec_t vec[19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: score the handshakes in effect at this edge, then step past it.
  task automatic tick();
    logic acc, drn;
    acc = in_valid && in_ready && !flush;
    drn = out_valid && out_ready && !flush;
    if (flush) exp_q.delete();
    if (drn) begin
      if (exp_q.size() == 0) chk("sb_unexpected", 64'd1, 64'd0);
      else chk("sb_rd", out_rd, exp_q.pop_front());
    end
    if (acc) exp_q.push_back(in_instr[11:7]);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_kind"}, out_kind, ak_invalid);
    chk({tag, "_rd"}, out_rd, 0);
    chk({tag, "_rs1"}, out_rs1, 0);
    chk({tag, "_rs2"}, out_rs2, 0);
    chk({tag, "_imm"}, out_imm, 0);
    chk({tag, "_use_imm"}, out_use_imm, 0);
    chk({tag, "_illegal"}, out_illegal, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cnt;
    int k;
    logic [31:0] w[4];

    vec[0]  = '{32'hFFF10093, ak_addi,    5'd1, 5'd2, 5'd31, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0};
    vec[1]  = '{32'h06432293, ak_slti,    5'd5, 5'd6, 5'd4,  32'h00000064, 1'b1, 1'b1, 1'b0};
    vec[2]  = '{32'h80043393, ak_sltiu,   5'd7, 5'd8, 5'd0,  32'hFFFFF800, 1'b1, 1'b1, 1'b0};
    vec[3]  = '{32'h7FF0C093, ak_xori,    5'd1, 5'd1, 5'd31, 32'h000007FF, 1'b1, 1'b1, 1'b0};
    vec[4]  = '{32'h0011E113, ak_ori,     5'd2, 5'd3, 5'd1,  32'h00000001, 1'b1, 1'b1, 1'b0};
    vec[5]  = '{32'h0F02F213, ak_andi,    5'd4, 5'd5, 5'd16, 32'h000000F0, 1'b1, 1'b1, 1'b0};
    vec[6]  = '{32'h01F11093, ak_slli,    5'd1, 5'd2, 5'd31, 32'd31,       1'b1, 1'b1, 1'b0};
    vec[7]  = '{32'h00525193, ak_srli,    5'd3, 5'd4, 5'd5,  32'd5,        1'b1, 1'b1, 1'b0};
    vec[8]  = '{32'h40725193, ak_srai,    5'd3, 5'd4, 5'd7,  32'd7,        1'b1, 1'b1, 1'b0};
    vec[9]  = '{32'h43F0D093, ak_invalid, 5'd1, 5'd1, 5'd31, 32'h0000043F, 1'b1, 1'b1, 1'b1};
    vec[10] = '{32'h003100B3, ak_add,     5'd1, 5'd2, 5'd3,  32'h00000003, 1'b1, 1'b0, 1'b0};
    vec[11] = '{32'h407302B3, ak_sub,     5'd5, 5'd6, 5'd7,  32'h00000407, 1'b1, 1'b0, 1'b0};
    vec[12] = '{32'h003130B3, ak_sltu,    5'd1, 5'd2, 5'd3,  32'h00000003, 1'b1, 1'b0, 1'b0};
    vec[13] = '{32'h403150B3, ak_sra,     5'd1, 5'd2, 5'd3,  32'h0,        1'b0, 1'b0, 1'b0};
    vec[14] = '{32'h00A4F433, ak_and,     5'd8, 5'd9, 5'd10, 32'h0000000A, 1'b1, 1'b0, 1'b0};
    vec[15] = '{32'h403110B3, ak_invalid, 5'd1, 5'd2, 5'd3,  32'h00000403, 1'b1, 1'b0, 1'b1};
    vec[16] = '{32'h12345037, ak_invalid, 5'd0, 5'd8, 5'd3,  32'h00000123, 1'b1, 1'b0, 1'b1};
`ifdef DECODE_ARITH_M_EXT_EN
    vec[17] = '{32'h023100B3, ak_mul,     5'd1, 5'd2, 5'd3,  32'h00000023, 1'b1, 1'b0, 1'b0};
`else
    vec[17] = '{32'h023100B3, ak_invalid, 5'd1, 5'd2, 5'd3,  32'h00000023, 1'b1, 1'b0, 1'b1};
`endif
    vec[18] = '{32'h02011093, ak_invalid, 5'd1, 5'd2, 5'd0,  32'h00000020, 1'b1, 1'b1, 1'b1};

    // Clock/reset
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // Decode table, one word at a time
    out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      in_valid = 1'b1;
      in_instr = vec[i].instr;
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_out_valid", i), out_valid, 1);
      chk($sformatf("v%0d_kind", i), out_kind, vec[i].kind);
      chk($sformatf("v%0d_rd", i), out_rd, vec[i].rd);
      chk($sformatf("v%0d_rs1", i), out_rs1, vec[i].rs1);
      chk($sformatf("v%0d_rs2", i), out_rs2, vec[i].rs2);
      if (vec[i].chk_imm) chk($sformatf("v%0d_imm", i), out_imm, vec[i].imm);
      chk($sformatf("v%0d_use_imm", i), out_use_imm, vec[i].use_imm);
      chk($sformatf("v%0d_illegal", i), out_illegal, vec[i].illegal);
      if (vec[i].instr == 32'h43F0D093) begin
        chk("x64_srai_kind", w_kind, ak_srai);
        chk("x64_srai_imm", w_imm, 64'd63);
        chk("x64_srai_illegal", w_illegal, 0);
      end
      tick();
    end
    chk("table_drained", out_valid, 0);

    w[0] = vec[1].instr;
    w[1] = vec[2].instr;
    w[2] = vec[4].instr;
    w[3] = vec[5].instr;

    // Back-to-back stream with out_ready held high
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_instr = w[i];
      tick();
      chk($sformatf("tp%0d_out_valid", i), out_valid, 1);
      chk($sformatf("tp%0d_in_ready", i), in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("tp_end_out_valid", out_valid, 0);
    chk("tp_queue_empty", exp_q.size(), 0);

    // Backpressure: four offered, two absorbed
    out_ready = 1'b0;
    acc_cnt = 0;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_instr = w[k];
      if (in_ready) begin
        acc_cnt++;
        k++;
      end
      tick();
      if (c == 0) chk("bp_ready_after_first", in_ready, 1);
      if (c == 1) chk("bp_ready_after_skid", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc_cnt, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_hold_rd", out_rd, 5'd5);
    out_ready = 1'b1;
    tick();
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_rd", out_rd, 5'd7);
    chk("bp_ready_back", in_ready, 1);
    tick();
    chk("bp_drained", out_valid, 0);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Flush with both entries full and a word offered
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = w[0];
    tick();
    in_instr = w[1];
    tick();
    chk("fl_full_ready", in_ready, 0);
    in_instr = w[2];
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    chk("fl_nothing_left", out_valid, 0);

    // Flush drops a same-cycle accept while in_ready is high
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = w[0];
    tick();
    in_instr = w[3];
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl2_out_valid", out_valid, 0);
    chk("fl2_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    chk("fl2_dropped", out_valid, 0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = vec[0].instr;
    tick();
    in_valid = 1'b0;
    in_instr = vec[1].instr;
    tick();
    chk("rs_pre_valid", out_valid, 1);
    #1 rst = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rs_after_release", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_arith_stage.md
# decode_arith_stage

Registered decode stage for RV integer arithmetic instructions. It accepts a raw 32-bit instruction word over a valid/ready handshake and decodes both OP-IMM (0010011) and OP (0110011) into an arith kind, register indices, a sign-extended immediate and an illegal flag. It is parametrised in XLEN, which selects the RV32 or RV64 shamt rules. A two-entry skid buffer sustains one instruction per cycle under backpressure with a registered `in_ready`. It sits between fetch and the ALU issue logic.

## Interface
- `XLEN`, 32, datapath width; legal values are 32 and 64. Sets the shamt width and the immediate width.
- `clk` input 1 — sole clock, rising edge.
- `rst` input 1 — reset, asynchronous, active-low.
- `flush` input 1 — synchronous clear of all buffered entries.
- `in_valid` input 1 — instruction presented.
- `in_ready` output 1 — stage can accept this cycle.
- `in_instr` input 32 — raw instruction word.
- `out_valid` output 1 — decoded entry presented.
- `out_ready` input 1 — consumer accepts this cycle.
- `out_kind` output `arith_kind_t` — decoded operation.
- `out_rd`, `out_rs1`, `out_rs2` output 5 each — instruction fields [11:7], [19:15], [24:20].
- `out_imm` output XLEN — sign-extended I-immediate, or the zero-extended shamt for shifts.
- `out_use_imm` output 1 — 1 for OP-IMM, 0 for OP.
- `out_illegal` output 1 — the opcode/funct combination is not decodable.

## Operation
- Decode, OP-IMM:
  - funct3 000 → addi, 010 → slti, 011 → sltiu, 100 → xori, 110 → ori, 111 → andi.
  - funct3 001 → slli; 101 → srli or srai.
  - XLEN=32: shift upper bits are [31:25]. slli/srli require 0000000; srai requires 0100000. The shamt is [24:20].
  - XLEN=64: shift upper bits are [31:26]. slli/srli require 000000; srai requires 010000. The shamt is [25:20].
- Decode, OP:
  - funct7 0000000 with funct3 000..111 → add, sll, slt, sltu, xor, srl, or, and.
  - funct7 0100000 with funct3 000 → sub; with funct3 101 → sra.
- Illegal entries: any other combination, and any other opcode, give kind `ak_invalid` with `out_illegal`=1. Illegal entries still flow through the handshake.
- Immediate: `out_imm` = sign-extension of [31:20] to XLEN, except for shift kinds, where it is the shamt zero-extended.
- Buffering: a main register plus a one-entry skid register.
  - `in_ready` = ~skid_valid, driven from a flop.
  - Accept when `in_valid && in_ready`.
  - An accepted word is decoded combinationally and written to main if main is empty or being drained this cycle; otherwise it is written to skid.
  - When main drains and skid is full, skid moves to main.
- Output hold: the payload is stable and `out_valid` is held while `out_valid && !out_ready`.
- `flush`: clears main and skid valid bits on the next edge and drops any same-cycle accept. It takes priority over every other event.

## Timing
- Reset (asynchronous assert): `out_valid`=0, skid empty, `in_ready`=1, `out_kind`=`ak_invalid`. `out_rd`, `out_rs1`, `out_rs2`, `out_imm`, `out_use_imm` and `out_illegal` are all 0.
- Reset mid-operation discards both entries immediately.
- Latency: an accept at edge N gives `out_valid` after edge N, so the entry is visible in cycle N+1.
- Throughput: 1 per cycle when `out_ready` is held high.
- Backpressure: with `out_ready`=0, the stage absorbs exactly 2 entries. `in_ready` falls the cycle after the skid register fills.
- Simultaneous events: an accept and a drain in the same cycle with skid empty keep the skid register empty.

## Configuration
- `DECODE_ARITH_M_EXT_EN` defined: OP with funct7 0000001 decodes funct3 000..111 → mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
- Not defined: those encodings decode as `ak_invalid` with `out_illegal`=1, and the M kinds are absent from the decode logic.

## Structure
- Package `instr_type` holds:
  - the `arith_kind_t` enum, including `ak_invalid` and the M kinds (always declared);
  - the opcode constants `OPC_OP_IMM` and `OPC_OP`;
  - the funct7 constants `F7_BASE`, `F7_ALT` and `F7_MULDIV`.
- Sub-module `arith_kind_lut`: purely combinational. Takes opcode, funct3 and the funct upper bits, with XLEN as a parameter, and produces the kind and illegal flag. It is instantiated once, on the input side.

## Test plan
- Reset, then `in_instr`=0xFFF10093 (addi x1,x2,-1) → one cycle later `ak_addi`, rd=1, rs1=2, `out_imm`=all ones, `out_use_imm`=1.
- XLEN=64, 0x43F0D093 → `ak_srai`, `out_imm`=63. XLEN=32, same word → `ak_invalid`, `out_illegal`=1.
- 0x023100B3 (mul x1,x2,x3) → `ak_mul`, rs2=3 with the macro defined. Without the macro → `out_illegal`=1.
- `out_ready`=0 while streaming 4 instructions → exactly 2 accepted, `in_ready`=0. Then `out_ready`=1 → both delivered in order on consecutive cycles, no loss or duplicate.
- `flush` asserted with both entries full and `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, the input word is dropped.
- `rst` dropped mid-stream while `out_valid`=1 → `out_valid`=0 immediately and all payload outputs at their reset values.
